// File: rtl/adc_frame_collector_if.sv
// Sample-in / frame-out bundle between the ADC front end and adc_frame_collector.
// A sample transfers on a rising edge where sample_valid && sample_ready; sample_in is held with valid until then.
interface adc_frame_collector_if #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int N_POINTS       = 32
);
  logic [ADC_DATA_WIDTH-1:0]          sample_in;
  logic                               sample_valid;
  logic                               sample_ready;
  logic                               clear;
  logic [N_POINTS*ADC_DATA_WIDTH-1:0] frame_out;
  logic                               frame_strobe;
  logic                               PU_enable;

  modport master (
    output sample_in, sample_valid, clear,
    input  sample_ready, frame_out, frame_strobe, PU_enable
  );

  modport slave (
    input  sample_in, sample_valid, clear,
    output sample_ready, frame_out, frame_strobe, PU_enable
  );
endinterface

// File: rtl/adc_frame_collector.sv
// Collects serial ADC samples into N_POINTS-sample frames and presents each frame held stable to the FFT.
// Optional feature macro ADC_SIGN_CONV_EN: invert the sample MSB (offset-binary to two's complement) before storage.
module adc_frame_collector #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int N_POINTS       = 32,
  parameter int HOLD_CYCLES    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  adc_frame_collector_if.slave  bus,
  output logic                  state_dbg
);

  localparam int IW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int FW = N_POINTS * ADC_DATA_WIDTH;

  typedef enum logic {
    ST_FILL      = 1'b0,
    ST_WAIT_HOLD = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IW-1:0]             wr_idx;
  logic [HW-1:0]             hold_cnt;
  logic [FW-1:0]             fill_bank;
  logic [FW-1:0]             bank_with_new;
  logic [FW-1:0]             frame_q;
  logic                      strobe_q;
  logic                      pu_q;
  logic [ADC_DATA_WIDTH-1:0] sample_stored;
  logic                      ready;
  logic                      accept;
  logic                      last_accept;
  logic                      present;
  logic                      hold_zero;

`ifdef ADC_SIGN_CONV_EN
  assign sample_stored = {~bus.sample_in[ADC_DATA_WIDTH-1], bus.sample_in[ADC_DATA_WIDTH-2:0]};
`else
  assign sample_stored = bus.sample_in;
`endif

  assign hold_zero = (hold_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FILL;
    else        state <= state_nxt;
  end

  // Next-state logic; clear always returns to FILL and drops any pending frame
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = ST_FILL;
    end else begin
      case (state)
        ST_FILL:      if (last_accept && !hold_zero) state_nxt = ST_WAIT_HOLD;
        ST_WAIT_HOLD: if (hold_zero) state_nxt = ST_FILL;
        default:      state_nxt = ST_FILL;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    ready       = (state == ST_FILL);
    accept      = bus.sample_valid && ready;
    last_accept = accept && (wr_idx == IW'(N_POINTS - 1));
    present     = 1'b0;
    case (state)
      ST_FILL:      present = last_accept && hold_zero && !bus.clear;
      ST_WAIT_HOLD: present = hold_zero && !bus.clear;
      default:      present = 1'b0;
    endcase
  end

  // Bank image including a sample accepted this edge, so the last sample lands in the presented frame
  always_comb begin
    bank_with_new = fill_bank;
    if (accept) bank_with_new[int'(wr_idx) * ADC_DATA_WIDTH +: ADC_DATA_WIDTH] = sample_stored;
  end

  always_ff @(posedge clk) begin
    if (accept && !bus.clear) fill_bank <= bank_with_new;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx   <= '0;
      hold_cnt <= '0;
      frame_q  <= '0;
      strobe_q <= 1'b0;
      pu_q     <= 1'b0;
    end else begin
      strobe_q <= present;
      if (bus.clear)   wr_idx <= '0;
      else if (accept) wr_idx <= wr_idx + 1'b1;
      if (present) begin
        frame_q  <= bank_with_new;
        pu_q     <= 1'b1;
        hold_cnt <= HW'(HOLD_CYCLES - 1);
      end else if (!hold_zero) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign bus.sample_ready = ready;
  assign bus.frame_out    = frame_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.PU_enable    = pu_q;
  assign state_dbg        = (state == ST_WAIT_HOLD);

endmodule

// File: tb/tb_adc_frame_collector.sv
// Self-checking bench for adc_frame_collector (HOLD_CYCLES=40): table-driven frames plus clear/reset sequences.
module tb_adc_frame_collector;

  localparam int W    = 8;
  localparam int N    = 32;
  localparam int HOLD = 40;
  localparam int FW   = N * W;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] step;
    bit           alt;
    int           idle;
    int           exp_stall;
    int           exp_gap;
  } frame_vec_t;

  logic clk;
  logic reset;
  logic state_dbg;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   last_strobe_cyc;

  logic [FW-1:0] exp_q[$];
  int            gap_q[$];
  logic [FW-1:0] held_exp;
  logic          held_pu;

  frame_vec_t vecs[6];

  adc_frame_collector_if #(.ADC_DATA_WIDTH(W), .N_POINTS(N)) bus ();

  adc_frame_collector #(
    .ADC_DATA_WIDTH(W),
    .N_POINTS      (N),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] conv(input logic [W-1:0] s);
`ifdef ADC_SIGN_CONV_EN
    return s ^ 8'h80;
`else
    return s;
`endif
  endfunction

  function automatic logic [W-1:0] gen(input frame_vec_t v, input int k);
    if (v.alt) return (k % 2 == 0) ? v.base : v.step;
    return v.base + W'(k) * v.step;
  endfunction

  // Driver tasks: all inputs change 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, inout int stall);
    int guard;
    guard            = 0;
    bus.sample_in    = d;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    while (!bus.sample_ready && guard < 200) begin
      stall++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("ready_timeout", FW'(0), FW'(1));
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_vec_t v, input bit push, output int stall);
    logic [FW-1:0] e;
    e     = '0;
    stall = 0;
    for (int k = 0; k < N; k++) begin
      e[k*W +: W] = conv(gen(v, k));
      send(gen(v, k), stall);
    end
    if (push) begin
      exp_q.push_back(e);
      gap_q.push_back(v.exp_gap);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending_frames", FW'(exp_q.size()), FW'(0));
  endtask

  // Scoreboard: pops one expected frame per strobe, otherwise checks the held frame stays put
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      gap_q.delete();
      held_exp = '0;
      held_pu  = 1'b0;
    end else if (bus.frame_strobe) begin
      logic [FW-1:0] e;
      int            g;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", FW'(1), FW'(0));
      end else begin
        e = exp_q.pop_front();
        g = gap_q.pop_front();
        check("frame_data", bus.frame_out, e);
        if (g != 0) check("strobe_gap", FW'(cyc - last_strobe_cyc), FW'(g));
        held_exp = e;
      end
      held_pu = 1'b1;
      check("pu_on_strobe", FW'(bus.PU_enable), FW'(1));
      last_strobe_cyc = cyc;
    end else begin
      check("frame_hold", bus.frame_out, held_exp);
      check("pu_enable", FW'(bus.PU_enable), FW'(held_pu));
    end
  end

  initial begin
    int        stall;
    frame_vec_t fa;
    frame_vec_t fb;

    n_checks        = 0;
    n_pass          = 0;
    last_strobe_cyc = 0;
    held_exp        = '0;
    held_pu         = 1'b0;

    //          base   step   alt  idle stall gap
    vecs[0] = '{8'h00, 8'h01, 1'b0, 0,  0,  0};
    vecs[1] = '{8'h40, 8'h03, 1'b0, 0,  0,  HOLD};
    vecs[2] = '{8'hF0, 8'h01, 1'b0, 0,  8,  HOLD};
    vecs[3] = '{8'h07, 8'h25, 1'b0, 60, 0,  0};
    vecs[4] = '{8'h80, 8'hFF, 1'b1, 60, 0,  0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 0,  0,  HOLD};

    reset            = 1'b1;
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    #1 reset = 1'b0;
    #1;
    check("reset_frame_out", bus.frame_out, FW'(0));
    check("reset_strobe", FW'(bus.frame_strobe), FW'(0));
    check("reset_pu", FW'(bus.PU_enable), FW'(0));
    check("reset_ready", FW'(bus.sample_ready), FW'(1));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      idle(vecs[i].idle);
      send_frame(vecs[i], 1'b1, stall);
      check($sformatf("row%0d_ready_stall", i), FW'(stall), FW'(vecs[i].exp_stall));
    end
    wait_drain();

    // Partial frame of 0x55, clear with a valid sample on the same edge, then a full frame of 0x01
    idle(50);
    stall = 0;
    for (int k = 0; k < 10; k++) send(8'h55, stall);
    bus.clear        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'hAA;
    @(posedge clk);
    #1;
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    fa = '{8'h01, 8'h00, 1'b0, 0, 0, 0};
    send_frame(fa, 1'b1, stall);
    wait_drain();

    // Clear while a frame waits in WAIT_HOLD: that frame must never appear
    idle(50);
    fa = '{8'h20, 8'h02, 1'b0, 0, 0, 0};
    fb = '{8'hC0, 8'h01, 1'b0, 0, 0, 0};
    send_frame(fa, 1'b1, stall);
    send_frame(fb, 1'b0, stall);
    @(negedge clk);
    check("wait_hold_ready", FW'(bus.sample_ready), FW'(0));
    check("wait_hold_state", FW'(state_dbg), FW'(1));
    @(posedge clk);
    #1 bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
    @(negedge clk);
    check("clear_ready", FW'(bus.sample_ready), FW'(1));
    check("clear_state", FW'(state_dbg), FW'(0));
    idle(60);
    fa = '{8'h11, 8'h01, 1'b0, 0, 0, 0};
    send_frame(fa, 1'b1, stall);
    wait_drain();

    // Async reset while a frame is pending in WAIT_HOLD
    idle(50);
    fa = '{8'h33, 8'h05, 1'b0, 0, 0, 0};
    fb = '{8'h99, 8'h07, 1'b0, 0, 0, 0};
    send_frame(fa, 1'b1, stall);
    send_frame(fb, 1'b1, stall);
    #1 reset = 1'b0;
    #1;
    check("async_rst_frame_out", bus.frame_out, FW'(0));
    check("async_rst_strobe", FW'(bus.frame_strobe), FW'(0));
    check("async_rst_pu", FW'(bus.PU_enable), FW'(0));
    check("async_rst_ready", FW'(bus.sample_ready), FW'(1));
    check("async_rst_state", FW'(state_dbg), FW'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset pulse after 20 samples, then a fresh k+100 frame with no stale data
    idle(5);
    stall = 0;
    for (int k = 0; k < 20; k++) send(W'(k + 200), stall);
    reset = 1'b0;
    #6 reset = 1'b1;
    @(posedge clk);
    #1;
    fa = '{8'd100, 8'h01, 1'b0, 0, 0, 0};
    send_frame(fa, 1'b1, stall);
    check("post_reset_ready_stall", FW'(stall), FW'(0));
    wait_drain();

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
